// File: rtl/i2s_audio_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : i2s_audio_receiver
//  Purpose  : I2S deserialiser. Oversamples bclk/lrclk/sdata in the clk
//             domain, verifies slot framing and recovers left/right PCM
//             words. A pcm_l/pcm_r pair is presented with a 1-clk pcm_valid
//             strobe at the end of every verified frame.
//  Revision : 1.0 - initial release
// ============================================================================
module i2s_audio_receiver #(
   parameter int AUDIO_BITS   = 16,
   parameter int SLOT_BITS    = 32,
   parameter int TIMEOUT_CLKS = 1024
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  bclk,
   input  logic                  lrclk,
   input  logic                  sdata,
   output logic [AUDIO_BITS-1:0] pcm_l,
   output logic [AUDIO_BITS-1:0] pcm_r,
   output logic                  pcm_valid,
   output logic                  locked,
   output logic                  frame_error
);

   localparam int IDLE_W = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT_CLKS);
   localparam logic [IDLE_W-1:0] IDLE_PRE  = IDLE_W'(TIMEOUT_CLKS - 1);
   localparam logic [5:0]        AUDIO_CNT = 6'(AUDIO_BITS);
   localparam logic [6:0]        SLOT_LEN  = 7'(SLOT_BITS);

   typedef enum logic [1:0] {
      ST_HUNT  = 2'd0,
      ST_LEFT  = 2'd1,
      ST_RIGHT = 2'd2
   } state_t;

   // synchroniser stages
   logic bclk_s1_q, bclk_s2_q, bclk_d_q;
   logic lrclk_s1_q, lrclk_s2_q;
   logic sdata_s1_q, sdata_s2_q;

   // framing / data state
   state_t                 state_q, state_d;
   logic [5:0]             bit_cnt_q, bit_cnt_d;
   logic                   lr_prev_q, lr_prev_d;
   logic [AUDIO_BITS-1:0]  shreg_q, shreg_d;
   logic [AUDIO_BITS-1:0]  hold_l_q, hold_l_d;
   logic [AUDIO_BITS-1:0]  hold_r_q, hold_r_d;
   logic [AUDIO_BITS-1:0]  pcm_l_q, pcm_l_d;
   logic [AUDIO_BITS-1:0]  pcm_r_q, pcm_r_d;
   logic                   pcm_valid_q, pcm_valid_d;
   logic                   locked_q, locked_d;
   logic                   frame_error_q, frame_error_d;
   logic [IDLE_W-1:0]      idle_q, idle_d;

   logic                   rise;
   logic                   boundary;
   logic                   slot_ok;
   logic [5:0]             cnt_inc;

   // Two-flop synchronisers plus one extra bclk stage for edge detection
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bclk_s1_q  <= 1'b0;
         bclk_s2_q  <= 1'b0;
         bclk_d_q   <= 1'b0;
         lrclk_s1_q <= 1'b0;
         lrclk_s2_q <= 1'b0;
         sdata_s1_q <= 1'b0;
         sdata_s2_q <= 1'b0;
      end else begin
         bclk_s1_q  <= bclk;
         bclk_s2_q  <= bclk_s1_q;
         bclk_d_q   <= bclk_s2_q;
         lrclk_s1_q <= lrclk;
         lrclk_s2_q <= lrclk_s1_q;
         sdata_s1_q <= sdata;
         sdata_s2_q <= sdata_s1_q;
      end
   end

   assign rise     = bclk_s2_q & ~bclk_d_q;
   assign boundary = rise & (lrclk_s2_q != lr_prev_q);
   // Length of the slot that a boundary rise closes (the boundary rise itself
   // belongs to the new slot, hence +1 on the last count).
   assign slot_ok  = (({1'b0, bit_cnt_q} + 7'd1) == SLOT_LEN);
   assign cnt_inc  = (bit_cnt_q == 6'd63) ? 6'd63 : bit_cnt_q + 6'd1;

   // Next-state logic: bit counting, shifting, capture, framing FSM, timeout
   always_comb begin
      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q;
      lr_prev_d     = lr_prev_q;
      shreg_d       = shreg_q;
      hold_l_d      = hold_l_q;
      hold_r_d      = hold_r_q;
      pcm_l_d       = pcm_l_q;
      pcm_r_d       = pcm_r_q;
      pcm_valid_d   = 1'b0;
      locked_d      = locked_q;
      frame_error_d = 1'b0;
      idle_d        = idle_q;

      if (rise) begin
         idle_d    = '0;
         lr_prev_d = lrclk_s2_q;
         bit_cnt_d = boundary ? 6'd0 : cnt_inc;

         // Data bits 1..AUDIO_BITS of the slot, MSB first
         if (!boundary && (bit_cnt_d <= AUDIO_CNT)) begin
            shreg_d = {shreg_q[AUDIO_BITS-2:0], sdata_s2_q};
            if (bit_cnt_d == AUDIO_CNT) begin
               if (state_q == ST_LEFT)  hold_l_d = shreg_d;
               if (state_q == ST_RIGHT) hold_r_d = shreg_d;
            end
         end

         case (state_q)
            ST_HUNT: begin
               // Slot length is not checked here: the stream may be joined
               // mid-slot, so only a clean edge to left is trusted.
               if (boundary && !lrclk_s2_q) state_d = ST_LEFT;
            end
            ST_LEFT: begin
               if (boundary) begin
                  if (slot_ok) begin
                     state_d = ST_RIGHT;
                  end else begin
                     state_d       = ST_HUNT;
                     locked_d      = 1'b0;
                     frame_error_d = 1'b1;
                  end
               end
            end
            ST_RIGHT: begin
               if (boundary) begin
                  if (slot_ok) begin
                     state_d     = ST_LEFT;
                     locked_d    = 1'b1;
                     pcm_l_d     = hold_l_q;
                     pcm_r_d     = hold_r_q;
                     pcm_valid_d = 1'b1;
                  end else begin
                     state_d       = ST_HUNT;
                     locked_d      = 1'b0;
                     frame_error_d = 1'b1;
                  end
               end
            end
            default: state_d = ST_HUNT;
         endcase
      end else if (idle_q != IDLE_MAX) begin
         idle_d = idle_q + 1'b1;
         // Fires once on the cycle the counter reaches its limit, then holds
         if (idle_q == IDLE_PRE) begin
            state_d       = ST_HUNT;
            locked_d      = 1'b0;
            frame_error_d = 1'b1;
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_HUNT;
         bit_cnt_q     <= '0;
         lr_prev_q     <= 1'b0;
         shreg_q       <= '0;
         hold_l_q      <= '0;
         hold_r_q      <= '0;
         pcm_l_q       <= '0;
         pcm_r_q       <= '0;
         pcm_valid_q   <= 1'b0;
         locked_q      <= 1'b0;
         frame_error_q <= 1'b0;
         idle_q        <= '0;
      end else begin
         state_q       <= state_d;
         bit_cnt_q     <= bit_cnt_d;
         lr_prev_q     <= lr_prev_d;
         shreg_q       <= shreg_d;
         hold_l_q      <= hold_l_d;
         hold_r_q      <= hold_r_d;
         pcm_l_q       <= pcm_l_d;
         pcm_r_q       <= pcm_r_d;
         pcm_valid_q   <= pcm_valid_d;
         locked_q      <= locked_d;
         frame_error_q <= frame_error_d;
         idle_q        <= idle_d;
      end
   end

   assign pcm_l       = pcm_l_q;
   assign pcm_r       = pcm_r_q;
   assign pcm_valid   = pcm_valid_q;
   assign locked      = locked_q;
   assign frame_error = frame_error_q;

endmodule
`default_nettype wire
